// File: rtl/lab1_bonus_if.sv
// Operand/result bundle for the lab1_bonus sign-magnitude adder.
// The master drives the operands; the slave returns the registered sum and overflow flag.
interface lab1_bonus_if;
  logic [2:0] a;
  logic [2:0] b;
  logic [2:0] o;
  logic       flag;

  modport master (
    output a,
    output b,
    input  o,
    input  flag
  );

  modport slave (
    input  a,
    input  b,
    output o,
    output flag
  );
endinterface

// File: rtl/lab1_bonus.sv
// Registered 3-bit sign-magnitude adder: sums two operands in -3..+3,
// saturates out-of-range results to +/-3 and raises flag when it does.
module lab1_bonus (
  input  logic         clk,
  input  logic         rst_n,
  lab1_bonus_if.slave  bus
);

  logic [2:0] opnd [2];
  logic [1:0] mag  [2];
  logic [1:0] sgn;

  logic [2:0] raw_mag;
  logic       res_sign;
  logic [1:0] sat_mag;
  logic       same_path;
  logic [2:0] o_next;
  logic       flag_next;
  logic [2:0] o_reg;
  logic       flag_reg;

  assign opnd[0] = bus.a;
  assign opnd[1] = bus.b;

  // A zero magnitude forces the effective sign positive, so -0 behaves as +0.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_decode
      assign mag[gi] = opnd[gi][1:0];
      assign sgn[gi] = opnd[gi][2] & (|opnd[gi][1:0]);
    end
  endgenerate

  always_comb begin
    raw_mag   = 3'd0;
    res_sign  = 1'b0;
    same_path = (mag[0] == 2'd0) || (mag[1] == 2'd0) || (sgn[0] == sgn[1]);
    if (same_path) begin
      raw_mag  = {1'b0, mag[0]} + {1'b0, mag[1]};
      res_sign = sgn[0] | sgn[1];
    end else if (mag[0] > mag[1]) begin
      raw_mag  = {1'b0, mag[0]} - {1'b0, mag[1]};
      res_sign = sgn[0];
    end else begin
      raw_mag  = {1'b0, mag[1]} - {1'b0, mag[0]};
      res_sign = sgn[1];
    end
  end

  // Zero results are canonicalised to 3'b000 regardless of the computed sign.
  always_comb begin
    flag_next = (raw_mag > 3'd3);
    sat_mag   = flag_next ? 2'b11 : raw_mag[1:0];
    o_next    = (sat_mag == 2'd0) ? 3'b000 : {res_sign, sat_mag};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_reg    <= 3'b000;
      flag_reg <= 1'b0;
    end else begin
      o_reg    <= o_next;
      flag_reg <= flag_next;
    end
  end

  assign bus.o    = o_reg;
  assign bus.flag = flag_reg;

endmodule

// File: tb/tb_lab1_bonus.sv
// Scoreboard bench for lab1_bonus: stimulus pushes integer-model results into a queue,
// a monitor pops and compares one cycle after each captured operand pair.
module tb_lab1_bonus;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [3:0] exp_q [$];

  lab1_bonus_if bus ();

  lab1_bonus dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: decode to signed integers, add, clamp, re-encode. Returns {flag, o}.
  function automatic logic [3:0] model(input logic [2:0] x, input logic [2:0] y);
    int vx = x[2] ? -int'(x[1:0]) : int'(x[1:0]);
    int vy = y[2] ? -int'(y[1:0]) : int'(y[1:0]);
    int s  = vx + vy;
    logic f = (s > 3) || (s < -3);
    int c  = (s > 3) ? 3 : ((s < -3) ? -3 : s);
    logic [1:0] m = (c < 0) ? 2'(-c) : 2'(c);
    return {f, (c < 0) ? 1'b1 : 1'b0, m};
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got flag=%b o=%b, expected flag=%b o=%b",
               name, act[3], act[2:0], req[3], req[2:0]);
    end
  endtask

  task automatic apply(input logic [2:0] x, input logic [2:0] y);
    @(negedge clk);
    bus.a = x;
    bus.b = y;
    exp_q.push_back(model(x, y));
  endtask

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      checks++;
      if (bus.o === 3'b100) begin
        errors++;
        $display("FAIL neg_zero_out: got o=%b, required never 100", bus.o);
      end
      if (exp_q.size() > 0) begin
        logic [3:0] e;
        e = exp_q.pop_front();
        check("result", {bus.flag, bus.o}, e);
        $display("txn: o=%b flag=%b expected o=%b flag=%b", bus.o, bus.flag, e[2:0], e[3]);
      end
    end
  end

  initial begin
    logic [2:0] ra;
    logic [2:0] rb;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.a  = 3'b011;
    bus.b  = 3'b011;
    repeat (3) @(negedge clk);
    check("reset_hold", {bus.flag, bus.o}, 4'b0_000);

    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(model(bus.a, bus.b));

    apply(3'b001, 3'b010);
    apply(3'b101, 3'b110);
    apply(3'b011, 3'b010);
    apply(3'b111, 3'b110);
    apply(3'b010, 3'b111);
    apply(3'b110, 3'b010);
    apply(3'b100, 3'b100);
    apply(3'b100, 3'b101);

    for (int i = 0; i <= 6; i++)
      for (int j = 0; j <= 6; j++)
        apply(3'(i), 3'(j));

    // Mid-stream reset: the pending result is discarded and outputs clear at once.
    apply(3'b011, 3'b011);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("async_reset", {bus.flag, bus.o}, 4'b0_000);
    repeat (2) @(negedge clk);
    check("reset_hold2", {bus.flag, bus.o}, 4'b0_000);
    bus.a = 3'b111;
    bus.b = 3'b111;
    rst_n = 1'b1;
    exp_q.push_back(model(bus.a, bus.b));

    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        apply(3'(i), 3'(j));

    for (int k = 0; k < 200; k++) begin
      ra = 3'($urandom_range(7, 0));
      rb = 3'($urandom_range(7, 0));
      apply(ra, rb);
    end

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending results, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
